// File: rtl/adc_avg_filter.sv
// adc_avg_filter: sliding-window moving average over the last 2^LOG2_DEPTH samples of an ADC
// byte stream, with a hysteresis alarm on the average and optional min/max tracking.
//
// Optional feature macro: ADC_FILTER_MINMAX_EN
//   defined   -> min_out/max_out track the smallest/largest sample since reset/clear
//   undefined -> min_out tied to all ones, max_out tied to zero (ports kept)
//
// Ports:
//   clk        in   system clock, posedge
//   rst        in   asynchronous active-high reset
//   data_in    in   raw sample, qualified by data_valid
//   data_valid in   single-cycle sample strobe
//   clear      in   synchronous flush of window, statistics and alarm (wins over data_valid)
//   avg_out    out  registered windowed average (truncated)
//   avg_valid  out  high once the window has been filled
//   avg_update out  one-cycle pulse per new average while valid
//   alarm      out  hysteresis flag: set at avg >= THRESH_HI, cleared at avg <= THRESH_LO
//   min_out    out  smallest sample since reset/clear
//   max_out    out  largest sample since reset/clear
module adc_avg_filter #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       LOG2_DEPTH = 3,
  parameter logic [DATA_W-1:0] THRESH_HI  = 8'hC0,
  parameter logic [DATA_W-1:0] THRESH_LO  = 8'h40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              clear,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              avg_update,
  output logic              alarm,
  output logic [DATA_W-1:0] min_out,
  output logic [DATA_W-1:0] max_out
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned SUM_W = DATA_W + LOG2_DEPTH;
  localparam int unsigned CNT_W = LOG2_DEPTH + 1;

  typedef enum logic [0:0] {StFill, StRun} state_e;

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       window_q [DEPTH];
  logic [DATA_W-1:0]       window_d [DEPTH];
  logic [SUM_W-1:0]        sum_q, sum_d;
  logic [LOG2_DEPTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DATA_W-1:0]       avg_q, avg_d;
  logic                    avg_valid_q, avg_valid_d;
  logic                    avg_update_q, avg_update_d;
  logic                    alarm_q, alarm_d;
  logic                    last_fill;

  // This sample completes the first full window.
  assign last_fill = (count_q == CNT_W'(DEPTH - 1));

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (state_q == StFill && data_valid && last_fill) begin
      state_d = StRun;
    end
    if (clear) begin
      state_d = StFill;
    end
  end

  // FSM outputs (next values of the registered status flags)
  always_comb begin
    count_d      = count_q;
    avg_valid_d  = avg_valid_q;
    avg_update_d = 1'b0;
    unique case (state_q)
      StFill: begin
        if (data_valid) begin
          count_d = count_q + 1'b1;
          if (last_fill) begin
            avg_valid_d  = 1'b1;
            avg_update_d = 1'b1;
          end
        end
      end
      StRun: begin
        avg_valid_d  = 1'b1;
        avg_update_d = data_valid;
      end
      default: ;
    endcase
    if (clear) begin
      count_d      = '0;
      avg_valid_d  = 1'b0;
      avg_update_d = 1'b0;
    end
  end

  // Window, running sum, average and alarm
  always_comb begin
    window_d = window_q;
    sum_d    = sum_q;
    wr_ptr_d = wr_ptr_q;
    avg_d    = avg_q;
    alarm_d  = alarm_q;
    if (clear) begin
      window_d = '{default: '0};
      sum_d    = '0;
      wr_ptr_d = '0;
      avg_d    = '0;
      alarm_d  = 1'b0;
    end else if (data_valid) begin
      // Sum width covers DEPTH full-scale samples, so the add/subtract cannot wrap.
      sum_d              = sum_q + SUM_W'(data_in) - SUM_W'(window_q[wr_ptr_q]);
      window_d[wr_ptr_q] = data_in;
      wr_ptr_d           = wr_ptr_q + 1'b1;
      avg_d              = sum_d[SUM_W-1:LOG2_DEPTH];
      if (avg_update_d) begin
        if (avg_d >= THRESH_HI) begin
          alarm_d = 1'b1;
        end else if (avg_d <= THRESH_LO) begin
          alarm_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window_q     <= '{default: '0};
      sum_q        <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      avg_q        <= '0;
      avg_valid_q  <= 1'b0;
      avg_update_q <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      window_q     <= window_d;
      sum_q        <= sum_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      avg_q        <= avg_d;
      avg_valid_q  <= avg_valid_d;
      avg_update_q <= avg_update_d;
      alarm_q      <= alarm_d;
    end
  end

  assign avg_out    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign avg_update = avg_update_q;
  assign alarm      = alarm_q;

`ifdef ADC_FILTER_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (clear) begin
      min_d = '1;
      max_d = '0;
    end else if (data_valid) begin
      if (data_in < min_q) min_d = data_in;
      if (data_in > max_q) max_d = data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_out = min_q;
  assign max_out = max_q;
`else
  assign min_out = '1;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_adc_avg_filter.sv
// Self-checking bench for adc_avg_filter (default parameters, depth 8).
// A reference model of the window produces the expected average/alarm for every sample once the
// window is full; those go into a queue and are popped whenever the DUT pulses avg_update.
module tb_adc_avg_filter;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       clear;
  logic [7:0] avg_out;
  logic       avg_valid;
  logic       avg_update;
  logic       alarm;
  logic [7:0] min_out;
  logic [7:0] max_out;

  adc_avg_filter dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .clear      (clear),
    .avg_out    (avg_out),
    .avg_valid  (avg_valid),
    .avg_update (avg_update),
    .alarm      (alarm),
    .min_out    (min_out),
    .max_out    (max_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {alarm, avg}
  logic [8:0] sb [$];

  // Reference model state
  logic [7:0] m_win [8];
  int         m_ptr;
  int         m_cnt;
  logic       m_alarm;
  logic [7:0] m_min;
  logic [7:0] m_max;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_win[i] = 8'h00;
    m_ptr   = 0;
    m_cnt   = 0;
    m_alarm = 1'b0;
    m_min   = 8'hFF;
    m_max   = 8'h00;
  endtask

  task automatic check_minmax(input string tag);
`ifdef ADC_FILTER_MINMAX_EN
    check({tag, "_min"}, {8'h00, min_out}, {8'h00, m_min});
    check({tag, "_max"}, {8'h00, max_out}, {8'h00, m_max});
`else
    check({tag, "_min"}, {8'h00, min_out}, 16'h00FF);
    check({tag, "_max"}, {8'h00, max_out}, 16'h0000);
`endif
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_avg"},    {8'h00, avg_out}, 16'h0000);
    check({tag, "_valid"},  {15'h0, avg_valid}, 16'h0000);
    check({tag, "_update"}, {15'h0, avg_update}, 16'h0000);
    check({tag, "_alarm"},  {15'h0, alarm}, 16'h0000);
    check({tag, "_min"},    {8'h00, min_out}, 16'h00FF);
    check({tag, "_max"},    {8'h00, max_out}, 16'h0000);
  endtask

  // Drive one sample for exactly one clock and update the model; returns 1 time unit after the edge.
  task automatic strobe(input logic [7:0] v);
    int s;
    logic [7:0] a;
    data_in    = v;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    m_win[m_ptr] = v;
    m_ptr = (m_ptr + 1) % 8;
    if (m_cnt < 8) m_cnt++;
    if (v < m_min) m_min = v;
    if (v > m_max) m_max = v;
    if (m_cnt == 8) begin
      s = 0;
      for (int i = 0; i < 8; i++) s += int'(m_win[i]);
      a = 8'(s / 8);
      if (a >= 8'hC0) m_alarm = 1'b1;
      else if (a <= 8'h40) m_alarm = 1'b0;
      sb.push_back({m_alarm, a});
    end
  endtask

  // n samples of value v; while still filling, the DUT must not report a valid average.
  task automatic feed(input int n, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      strobe(v);
      if (m_cnt < 8) begin
        check("fill_valid", {15'h0, avg_valid}, 16'h0000);
        check("fill_update", {15'h0, avg_update}, 16'h0000);
      end
    end
  endtask

  task automatic do_clear(input logic with_sample, input logic [7:0] v);
    clear      = 1'b1;
    data_valid = with_sample;
    data_in    = v;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    data_valid = 1'b0;
    model_reset();
    check_reset("clear");
  endtask

  // Scoreboard consumer: every avg_update pulse must match the next expected average.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && avg_update === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL unexpected_update: observed avg_update=1 avg %h expected no update", avg_out);
      end else begin
        e = sb.pop_front();
        check("avg", {8'h00, avg_out}, {8'h00, e[7:0]});
        check("alarm", {15'h0, alarm}, {15'h0, e[8]});
        check("valid_at_update", {15'h0, avg_valid}, 16'h0001);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    data_valid = 1'b0;
    data_in    = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    // First full window of 0x10, then one 0x20 sample evicting the oldest 0x10.
    feed(8, 8'h10);
    check("first_valid", {15'h0, avg_valid}, 16'h0001);
    feed(1, 8'h20);
    @(negedge clk);

    // Full-scale samples back to back: no overflow, alarm set.
    feed(8, 8'hFF);
    check_minmax("ff");
    @(negedge clk);

    // Hysteresis walk.
    do_clear(1'b0, 8'h00);
    feed(8, 8'hC0);
    feed(8, 8'h80);
    feed(8, 8'h00);
    feed(3, 8'h80);
    check_minmax("hyst");
    @(negedge clk);

    // Truncation: 7/8 -> 0.
    do_clear(1'b0, 8'h00);
    feed(7, 8'h00);
    feed(1, 8'h07);
    check_minmax("trunc");
    @(negedge clk);

    // Clear together with a sample mid-fill: the sample is discarded.
    do_clear(1'b0, 8'h00);
    feed(3, 8'h33);
    do_clear(1'b1, 8'h55);
    feed(7, 8'h44);
    feed(1, 8'h44);
    check_minmax("post_clear");
    @(negedge clk);

    // Asynchronous reset mid-run.
    feed(2, 8'hA0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_valid", {15'h0, avg_valid}, 16'h0000);
    check("arst_avg", {8'h00, avg_out}, 16'h0000);
    @(negedge clk);
    check_reset("arst");
    rst = 1'b0;
    @(negedge clk);
    feed(8, 8'h60);
    check("rst_refill_valid", {15'h0, avg_valid}, 16'h0001);
    repeat (3) @(negedge clk);

    check("sb_empty", 16'(sb.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_avg_filter.md
Name: adc_avg_filter

Overview:
- Downstream consumer of the PCF8591 I2C reader's 8-bit sample byte.
- Keeps a sliding-window moving average over the last 2^LOG2_DEPTH samples.
- Raises a hysteresis threshold alarm on the average and tracks min/max raw samples.
- Outputs feed display/control logic in the same clk domain.

Parameters:
- DATA_W, 8: width of sample and average.
- LOG2_DEPTH, 3: log2 of window length; depth = 8 samples by default; legal range 1..5.
- THRESH_HI, 8'hC0: alarm set level; compared against avg_out.
- THRESH_LO, 8'h40: alarm clear level; THRESH_LO < THRESH_HI is required.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_W  raw sample from the I2C reader.
- data_valid  input  1  single-cycle strobe; data_in is valid this cycle.
- clear  input  1  synchronous flush of window, statistics and alarm.
- avg_out  output  DATA_W  windowed average, registered.
- avg_valid  output  1  level; high once the window is full.
- avg_update  output  1  one-cycle pulse each time avg_out changes while avg_valid is high.
- alarm  output  1  hysteresis threshold flag.
- min_out  output  DATA_W  smallest sample since reset/clear.
- max_out  output  DATA_W  largest sample since reset/clear.

Behaviour:
- Reset values (async assert; deassert sampled on clk):
  - avg_out=0, avg_valid=0, avg_update=0, alarm=0.
  - min_out=all ones, max_out=0.
  - All window entries=0, sum=0, wr_ptr=0, fill count=0, state=FILL.
- Storage and pointer:
  - Window is a circular register array of 2^LOG2_DEPTH entries.
  - wr_ptr is LOG2_DEPTH bits and wraps naturally from depth-1 to 0.
- Sum arithmetic:
  - sum is DATA_W+LOG2_DEPTH bits, so it never overflows (all-ones samples fit exactly).
  - On an edge with data_valid=1: window[wr_ptr]<=data_in; sum<=sum+data_in-window[wr_ptr]; wr_ptr<=wr_ptr+1.
- Average:
  - avg_out <= next_sum >> LOG2_DEPTH, truncating with no rounding.
  - avg_out is updated on the same edge as the sum, giving latency 1 cycle from the data_valid cycle.
- State machine:
  - FILL: count increments per sample; avg_out is updated but avg_valid=0 and avg_update=0.
  - FILL→RUN: on the sample that makes count = depth, avg_valid<=1 and avg_update<=1 on that same edge.
  - RUN: every data_valid edge gives avg_update<=1 for one cycle; otherwise avg_update<=0.
- Back-to-back data_valid on consecutive cycles is fully supported with no stall; no backpressure is provided.
- Alarm (evaluated only on edges where avg_update is asserted, using the new average):
  - Set when new avg >= THRESH_HI.
  - Cleared when new avg <= THRESH_LO.
  - Otherwise holds its value.
  - No alarm change during FILL.
- Min/max: on every data_valid, min_out<=min(min_out,data_in) and max_out<=max(max_out,data_in), in both FILL and RUN.
- Clear:
  - Returns every register to its reset value on the next edge.
  - clear and data_valid in the same cycle: clear wins and the sample is discarded.
- Reset mid-operation: all state is lost immediately; outputs take reset values asynchronously.
- data_in is ignored when data_valid=0; holding data_valid high for N cycles counts as N samples.

Optional Feature:
- ADC_FILTER_MINMAX_EN defined: min/max tracking is present as described above.
- ADC_FILTER_MINMAX_EN undefined:
  - The comparators and registers are removed.
  - min_out is tied to all ones and max_out is tied to 0.
  - The ports remain so that instantiations are unchanged.

Test Plan:
- Eight strobes of data_in=8'h10 after reset → avg_valid and avg_update rise 1 cycle after the 8th strobe, avg_out=8'h10; no avg_update before that.
- Continue with a 9th strobe of 8'h20 → sum=0x90, avg_out=8'h12, one avg_update pulse; 8'h10 samples are evicted in order.
- Eight strobes of 8'hFF on consecutive cycles → avg_out=8'hFF (sum 0x7F8, no overflow), alarm=1, max_out=8'hFF.
- Hysteresis:
  - Fill with 8'hC0 → alarm=1.
  - Feed 8'h80 samples until avg=8'h80 → alarm stays 1.
  - Feed 8'h00 until avg<=8'h40 → alarm=0 on that update edge.
  - Feed 8'h80 again → alarm stays 0.
- Truncation and min: window filled with seven 8'h00 and one 8'h07 → avg_out=8'h00, min_out=8'h00, max_out=8'h07.
- Clear/reset:
  - clear asserted with data_valid=1 mid-FILL → all outputs at reset values next cycle and the sample is not counted.
  - rst asserted mid-RUN → avg_valid=0 immediately; 8 new samples are required before the next avg_update.
